// File: rtl/fft_agu_pp.sv
// Address generator and sequencer for an in-place radix-2 DIT FFT over ping-pong RAMs.
// Reads come from RAM[stage[0]]; results return LAT cycles later into the other RAM.
module fft_agu_pp #(
    parameter int LOGN = 11,
    parameter int LAT  = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic            rdsel,
    output logic            resultsel,
    output logic            we0,
    output logic [LOGN-1:0] adr0a,
    output logic [LOGN-1:0] adr0b,
    output logic            we1,
    output logic [LOGN-1:0] adr1a,
    output logic [LOGN-1:0] adr1b,
    output logic [LOGN-2:0] twiddleadr
);
    localparam int SW = $clog2(LOGN);
    localparam int BW = LOGN - 1;
    localparam logic [SW-1:0] LAST_STAGE = SW'(LOGN - 1);
    localparam logic [2:0]    LAT3       = 3'(LAT);
    localparam logic [BW-1:0] ALL_ONES   = {BW{1'b1}};

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   stage_q, stage_d;
    logic [BW-1:0]   bfly_q, bfly_d;
    logic [2:0]      drain_q, drain_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            stage_q <= '0;
            bfly_q  <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            bfly_q  <= bfly_d;
            drain_q <= drain_d;
        end
    end

    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        bfly_d  = bfly_q;
        drain_d = drain_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    stage_d = '0;
                    bfly_d  = '0;
                end
            end
            RUN: begin
                bfly_d = bfly_q + 1'b1;
                if (bfly_q == ALL_ONES) begin
                    state_d = DRAIN;
                    drain_d = LAT3;
                end
            end
            DRAIN: begin
                drain_d = drain_q - 1'b1;
                // The last drain cycle carries the final write of the stage.
                if (drain_q == 3'd1) begin
                    if (stage_q < LAST_STAGE) begin
                        state_d = RUN;
                        stage_d = stage_q + 1'b1;
                        bfly_d  = '0;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    logic              rd_valid;
    logic [LOGN-1:0]   ja, jb, rd_a, rd_b;
    logic [2*LOGN-1:0] rot_a, rot_b;

    // Rotate-left within LOGN bits: shift a doubled copy and keep the upper half.
    always_comb begin
        rd_valid = (state_q == RUN);
        ja       = {bfly_q, 1'b0};
        jb       = {bfly_q, 1'b1};
        rot_a    = {ja, ja} << stage_q;
        rot_b    = {jb, jb} << stage_q;
        rd_a     = rd_valid ? rot_a[2*LOGN-1 -: LOGN] : '0;
        rd_b     = rd_valid ? rot_b[2*LOGN-1 -: LOGN] : '0;
    end

    logic [LOGN-1:0] dl_a_q [LAT];
    logic [LOGN-1:0] dl_b_q [LAT];
    logic [LAT-1:0]  dl_v_q;
    logic [LAT-1:0]  dl_s_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < LAT; i++) begin
                dl_a_q[i] <= '0;
                dl_b_q[i] <= '0;
            end
            dl_v_q <= '0;
            dl_s_q <= '0;
        end else begin
            dl_a_q[0] <= rd_a;
            dl_b_q[0] <= rd_b;
            dl_v_q[0] <= rd_valid;
            dl_s_q[0] <= stage_q[0];
            for (int i = 1; i < LAT; i++) begin
                dl_a_q[i] <= dl_a_q[i-1];
                dl_b_q[i] <= dl_b_q[i-1];
                dl_v_q[i] <= dl_v_q[i-1];
                dl_s_q[i] <= dl_s_q[i-1];
            end
        end
    end

    logic            wr_v, wr_s;
    logic [LOGN-1:0] wr_a, wr_b;

    always_comb begin
        wr_v       = dl_v_q[LAT-1];
        wr_s       = dl_s_q[LAT-1];
        wr_a       = dl_a_q[LAT-1];
        wr_b       = dl_b_q[LAT-1];
        busy       = (state_q == RUN) || (state_q == DRAIN);
        done       = (state_q == DONE);
        rdsel      = stage_q[0];
        we0        = wr_v & wr_s;
        we1        = wr_v & ~wr_s;
        adr0a      = (rd_valid & ~rdsel) ? rd_a : (we0 ? wr_a : '0);
        adr0b      = (rd_valid & ~rdsel) ? rd_b : (we0 ? wr_b : '0);
        adr1a      = (rd_valid & rdsel)  ? rd_a : (we1 ? wr_a : '0);
        adr1b      = (rd_valid & rdsel)  ? rd_b : (we1 ? wr_b : '0);
        twiddleadr = rd_valid ? (bfly_q & ~(ALL_ONES >> stage_q)) : '0;
    end

    assign resultsel = (((LOGN - 1) % 2) == 0);
endmodule

// File: tb/tb_fft_agu_pp.sv
// Bench for fft_agu_pp: a LOGN=3/LAT=1 instance checked against hand tables and a
// LOGN=4/LAT=3 instance checked against a bit-level model, sharing clk/reset/start.
module tb_fft_agu_pp;
    localparam int MAXC = 512;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    always #5 clk = ~clk;

    logic       busy_0, done_0, rdsel_0, rsel_0, we0_0, we1_0;
    logic [2:0] a0a_0, a0b_0, a1a_0, a1b_0;
    logic [1:0] tw_0;
    logic       busy_1, done_1, rdsel_1, rsel_1, we0_1, we1_1;
    logic [3:0] a0a_1, a0b_1, a1a_1, a1b_1;
    logic [2:0] tw_1;

    fft_agu_pp #(.LOGN(3), .LAT(1)) dut0 (
        .clk(clk), .reset(reset), .start(start), .busy(busy_0), .done(done_0),
        .rdsel(rdsel_0), .resultsel(rsel_0), .we0(we0_0), .adr0a(a0a_0), .adr0b(a0b_0),
        .we1(we1_0), .adr1a(a1a_0), .adr1b(a1b_0), .twiddleadr(tw_0)
    );

    fft_agu_pp #(.LOGN(4), .LAT(3)) dut1 (
        .clk(clk), .reset(reset), .start(start), .busy(busy_1), .done(done_1),
        .rdsel(rdsel_1), .resultsel(rsel_1), .we0(we0_1), .adr0a(a0a_1), .adr0b(a0b_1),
        .we1(we1_1), .adr1a(a1a_1), .adr1b(a1b_1), .twiddleadr(tw_1)
    );

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int  vectors = 0;
    int  miscompares = 0;
    bit  mon_en = 1'b0;

    // Expected busy (bit 1) / done (bit 0) per instance and cycle.
    logic [1:0]  tl [2][MAXC];
    // Item: {pad3, dut, cycle[15:0], ram, a[11:0], b[11:0], tw[10:0]}
    logic [55:0] rd_q[$];
    logic [55:0] wr_q[$];

    int h_a[12] = '{0, 2, 4, 6, 0, 4, 1, 5, 0, 1, 2, 3};
    int h_b[12] = '{1, 3, 5, 7, 2, 6, 3, 7, 4, 5, 6, 7};
    int h_t[12] = '{0, 0, 0, 0, 0, 0, 2, 2, 0, 1, 2, 3};

    function automatic logic [55:0] mk(int d, int c, int ram, int a, int b, int tw);
        return {3'b000, 1'(d), 16'(c), 1'(ram), 12'(a), 12'(b), 11'(tw)};
    endfunction

    function automatic int rotl_m(int v, int s, int n);
        int r = 0;
        for (int i = 0; i < n; i++)
            if (v[i]) r = r | (1 << ((i + s) % n));
        return r;
    endfunction

    task automatic push_run(input int d, input int c0);
        int n, lat, half, tot, rc, a, b, tw, msk;
        n    = (d == 0) ? 3 : 4;
        lat  = (d == 0) ? 1 : 3;
        half = 1 << (n - 1);
        tot  = n * (half + lat);
        if (tl[d][c0][1]) return;
        msk = (1 << (n - 1)) - 1;
        for (int s = 0; s < n; s++) begin
            for (int k = 0; k < half; k++) begin
                rc = c0 + 1 + s * (half + lat) + k;
                if (d == 0) begin
                    a  = h_a[s*4+k];
                    b  = h_b[s*4+k];
                    tw = h_t[s*4+k];
                end else begin
                    a  = rotl_m(2 * k, s, n);
                    b  = rotl_m(2 * k + 1, s, n);
                    tw = ((msk << (n - 1 - s)) & msk) & k;
                end
                rd_q.push_back(mk(d, rc, s % 2, a, b, tw));
                wr_q.push_back(mk(d, rc + lat, 1 - (s % 2), a, b, 0));
            end
        end
        for (int m = c0 + 1; m < MAXC; m++)
            tl[d][m] = (m <= c0 + tot) ? 2'b10 : 2'b01;
    endtask

    task automatic flush_after(input int k);
        for (int i = rd_q.size() - 1; i >= 0; i--)
            if (rd_q[i][51:36] > 16'(k)) rd_q.delete(i);
        for (int i = wr_q.size() - 1; i >= 0; i--)
            if (wr_q[i][51:36] > 16'(k)) wr_q.delete(i);
        for (int d = 0; d < 2; d++)
            for (int m = k + 1; m < MAXC; m++) tl[d][m] = 2'b00;
    endtask

    task automatic match(input bit is_wr, input int d, input logic [55:0] obs);
        int idx = -1;
        logic [55:0] exp_item;
        vectors++;
        if (!is_wr) begin
            for (int i = 0; i < rd_q.size(); i++)
                if (idx < 0 && rd_q[i][52] == 1'(d)) idx = i;
            if (idx >= 0) begin exp_item = rd_q[idx]; rd_q.delete(idx); end
        end else begin
            for (int i = 0; i < wr_q.size(); i++)
                if (idx < 0 && wr_q[i][52] == 1'(d)) idx = i;
            if (idx >= 0) begin exp_item = wr_q[idx]; wr_q.delete(idx); end
        end
        if (idx < 0) begin
            miscompares++;
            $display("FAIL %s_unexpected dut%0d cyc %0d: got %h required none", is_wr ? "wr" : "rd", d, cyc, obs);
        end else if (exp_item != obs) begin
            miscompares++;
            $display("FAIL %s dut%0d cyc %0d: got %h required %h", is_wr ? "wr" : "rd", d, cyc, obs, exp_item);
        end
    endtask

    task automatic check_dut(input int d, input logic bz, input logic dn, input logic rs,
                             input logic w0, input logic w1,
                             input logic [11:0] x0a, input logic [11:0] x0b,
                             input logic [11:0] x1a, input logic [11:0] x1b,
                             input logic [10:0] tw);
        bit rd0, rd1;
        vectors++;
        if (w0 && w1) begin
            miscompares++;
            $display("FAIL we_overlap dut%0d cyc %0d: got we0=1 we1=1 required not both", d, cyc);
        end
        vectors++;
        if ({bz, dn} != tl[d][cyc]) begin
            miscompares++;
            $display("FAIL busy_done dut%0d cyc %0d: got %b required %b", d, cyc, {bz, dn}, tl[d][cyc]);
        end
        rd0 = !w0 && (x0a != x0b);
        rd1 = !w1 && (x1a != x1b);
        if (rd0 || rd1) begin
            vectors++;
            if (rs != rd1) begin
                miscompares++;
                $display("FAIL rdsel dut%0d cyc %0d: got %b required %b", d, cyc, rs, rd1);
            end
        end
        if (rd0) match(1'b0, d, mk(d, cyc, 0, x0a, x0b, tw));
        if (rd1) match(1'b0, d, mk(d, cyc, 1, x1a, x1b, tw));
        if (w0)  match(1'b1, d, mk(d, cyc, 0, x0a, x0b, 0));
        if (w1)  match(1'b1, d, mk(d, cyc, 1, x1a, x1b, 0));
        if (!rd0 && !w0) begin
            vectors++;
            if ((x0a | x0b) != 0) begin
                miscompares++;
                $display("FAIL ram0_idle_adr dut%0d cyc %0d: got %h/%h required 0/0", d, cyc, x0a, x0b);
            end
        end
        if (!rd1 && !w1) begin
            vectors++;
            if ((x1a | x1b) != 0) begin
                miscompares++;
                $display("FAIL ram1_idle_adr dut%0d cyc %0d: got %h/%h required 0/0", d, cyc, x1a, x1b);
            end
        end
        if (!rd0 && !rd1) begin
            vectors++;
            if (tw != 0) begin
                miscompares++;
                $display("FAIL tw_idle dut%0d cyc %0d: got %h required 0", d, cyc, tw);
            end
        end
        for (int i = rd_q.size() - 1; i >= 0; i--)
            if (rd_q[i][52] == 1'(d) && rd_q[i][51:36] < 16'(cyc)) begin
                vectors++; miscompares++;
                $display("FAIL rd_missed dut%0d cyc %0d: got nothing required %h", d, cyc, rd_q[i]);
                rd_q.delete(i);
            end
        for (int i = wr_q.size() - 1; i >= 0; i--)
            if (wr_q[i][52] == 1'(d) && wr_q[i][51:36] < 16'(cyc)) begin
                vectors++; miscompares++;
                $display("FAIL wr_missed dut%0d cyc %0d: got nothing required %h", d, cyc, wr_q[i]);
                wr_q.delete(i);
            end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (mon_en && cyc < MAXC) begin
                check_dut(0, busy_0, done_0, rdsel_0, we0_0, we1_0, 12'(a0a_0), 12'(a0b_0),
                          12'(a1a_0), 12'(a1b_0), 11'(tw_0));
                check_dut(1, busy_1, done_1, rdsel_1, we0_1, we1_1, 12'(a0a_1), 12'(a0b_1),
                          12'(a1a_1), 12'(a1b_1), 11'(tw_1));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic goto(input int c);
        while (cyc < c) step();
    endtask

    task automatic pulse_start();
        push_run(0, cyc);
        push_run(1, cyc);
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    int c0, c1, c2;

    initial begin
        for (int d = 0; d < 2; d++)
            for (int m = 0; m < MAXC; m++) tl[d][m] = 2'b00;
        reset = 1'b1;
        repeat (3) step();
        mon_en = 1'b1;
        step();
        reset = 1'b0;
        step();
        step();

        vectors++;
        if (rsel_0 !== 1'b1) begin
            miscompares++;
            $display("FAIL resultsel dut0: got %b required 1", rsel_0);
        end
        vectors++;
        if (rsel_1 !== 1'b0) begin
            miscompares++;
            $display("FAIL resultsel dut1: got %b required 0", rsel_1);
        end

        // Full run on both; a start while busy; a relaunch of dut0 from DONE.
        c0 = int'(cyc);
        pulse_start();
        goto(c0 + 3);
        pulse_start();
        goto(c0 + 20);
        pulse_start();
        goto(c0 + 70);

        // Abort dut0 in the middle of stage 1, then restart from scratch.
        c1 = int'(cyc);
        pulse_start();
        goto(c1 + 7);
        reset = 1'b1;
        flush_after(c1 + 7);
        step();
        reset = 1'b0;
        step();
        step();

        c2 = int'(cyc);
        pulse_start();
        goto(c2 + 60);
        step();

        vectors++;
        if (rd_q.size() != 0) begin
            miscompares++;
            $display("FAIL rd_leftover: got %0d pending required 0", rd_q.size());
        end
        vectors++;
        if (wr_q.size() != 0) begin
            miscompares++;
            $display("FAIL wr_leftover: got %0d pending required 0", wr_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
